// File: rtl/fetch_stage_pkg.sv
// ============================================================================
// Module  : fetch_stage_pkg
// Brief   : Shared defines, types and helpers for the instruction-fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NOP_INSTR
`define NOP_INSTR 32'hE000_0000
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

package fetch_stage_pkg;

    localparam int ADDR_W  = `ADDR_W;
    localparam int INSTR_W = `INSTR_W;
    localparam logic [INSTR_W-1:0] NOP_WORD = `NOP_INSTR;

    // Source of the next program counter value
    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_SEQ    = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_e;

    // Saturating 32-bit increment used by the performance counters
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register (instruction, PC+4, valid) with
//           load / flush / hold controls. Flush has priority over load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NOP_INSTR
`define NOP_INSTR 32'hE000_0000
`endif

module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                flush_i,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [ADDR_W-1:0]   pc_i,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               valid_q, valid_d;

    // Next-state: flush inserts a bubble, load captures, otherwise hold
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = `NOP_INSTR;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    // Register with synchronous active-low reset to a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q <= `NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : Instruction-fetch stage: PC register, next-PC mux, sticky fetch
//           fault flag, IF/ID register and optional perf counters.
//           Optional feature macro: FETCH_PERF_CNT_EN (perf counters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    // Highest byte address from which a full word can still be fetched
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic        fault_q, fault_d;
    pc_sel_e     pc_sel;

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q;

    // Select next-PC source: branch overrides freeze, else sequential
    always_comb begin
        if (branch_taken)  pc_sel = PC_BRANCH;
        else if (freeze)   pc_sel = PC_HOLD;
        else               pc_sel = PC_SEQ;
    end

    // Next-PC mux and sticky fault accumulation
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        case (pc_sel)
            PC_BRANCH: begin
                pc_d = {branch_addr[31:2], 2'b00};
                if (branch_addr[1:0] != 2'b00) fault_d = 1'b1;
            end
            PC_SEQ: begin
                pc_d = pc_plus4;
                if (pc_q > LAST_PC) fault_d = 1'b1;
            end
            default: pc_d = pc_q;
        endcase
    end

    // PC and fault flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign fetch_fault = fault_q;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pc_sel == PC_SEQ),
        .flush_i (pc_sel == PC_BRANCH),
        .instr_i (imem_instr),
        .pc_i    (pc_plus4),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .valid_o (if_id_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    // Saturating event counters: fetch, stall, flush
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_sel == PC_SEQ)    fetch_cnt_q <= sat_inc(fetch_cnt_q);
            if (pc_sel == PC_HOLD)   stall_cnt_q <= sat_inc(stall_cnt_q);
            if (pc_sel == PC_BRANCH) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module  : tb_fetch_stage
// Brief   : Self-checking bench for fetch_stage: vector table with hand
//           expectations plus a reference model feeding an expected-value
//           queue. Honors FETCH_PERF_CNT_EN for counter expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] imem_instr;
    logic [31:0] imem_addr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Address-tagged instruction memory
    function automatic logic [31:0] tag(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction
    assign imem_instr = tag(imem_addr);

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(256)) dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem_instr     (imem_instr),
        .imem_addr      (imem_addr),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .fetch_fault    (fetch_fault),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct {
        logic [31:0] addr, ipc, instr, fcnt, scnt, flcnt;
        logic        valid, fault;
    } exp_t;

    typedef struct {
        logic        r, f, b;
        logic [31:0] a;
        logic [31:0] e_addr, e_ipc;
        logic        e_v, e_fault;
    } vec_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc = 0, m_ipc = 0, m_instr = NOP;
    logic        m_valid = 0, m_fault = 0;
    logic [31:0] m_fc = 0, m_sc = 0, m_flc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model for one edge and push the expected outputs
    task automatic model_step(input logic r, input logic f, input logic b, input logic [31:0] a);
        exp_t e;
        if (!r) begin
            m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_fault = 0;
            m_fc = 0; m_sc = 0; m_flc = 0;
        end else if (b) begin
            if (a[1:0] != 2'b00) m_fault = 1;
            m_pc = {a[31:2], 2'b00}; m_instr = NOP; m_ipc = 0; m_valid = 0; m_flc++;
        end else if (f) begin
            m_sc++;
        end else begin
            if (m_pc > 32'd252) m_fault = 1;
            m_instr = tag(m_pc); m_ipc = m_pc + 4; m_valid = 1; m_pc = m_pc + 4; m_fc++;
        end
        e.addr = m_pc; e.ipc = m_ipc; e.instr = m_instr; e.valid = m_valid; e.fault = m_fault;
`ifdef FETCH_PERF_CNT_EN
        e.fcnt = m_fc; e.scnt = m_sc; e.flcnt = m_flc;
`else
        e.fcnt = 0; e.scnt = 0; e.flcnt = 0;
`endif
        exp_q.push_back(e);
    endtask

    // Drive one cycle, then pop the scoreboard entry and compare
    task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
        exp_t e;
        @(negedge clk);
        rst = r; freeze = f; branch_taken = b; branch_addr = a;
        model_step(r, f, b, a);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("imem_addr",   imem_addr,   e.addr);
        chk("if_id_pc",    if_id_pc,    e.ipc);
        chk("if_id_instr", if_id_instr, e.instr);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
        chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
        chk("perf_fetch",  perf_fetch_cnt, e.fcnt);
        chk("perf_stall",  perf_stall_cnt, e.scnt);
        chk("perf_flush",  perf_flush_cnt, e.flcnt);
    endtask

    vec_t vt[18];

    initial begin
        rst = 0; freeze = 0; branch_taken = 0; branch_addr = 0;

        //          r  f  b  addr          e_addr         e_ipc          v  fault
        vt[0]  = '{1'b0,1'b0,1'b0,32'h0,  32'h0,         32'h0,         1'b0,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,32'h0,  32'h4,         32'h4,         1'b1,1'b0};
        vt[2]  = '{1'b1,1'b0,1'b0,32'h0,  32'h8,         32'h8,         1'b1,1'b0};
        vt[3]  = '{1'b1,1'b1,1'b0,32'h0,  32'h8,         32'h8,         1'b1,1'b0};
        vt[4]  = '{1'b1,1'b1,1'b0,32'h0,  32'h8,         32'h8,         1'b1,1'b0};
        vt[5]  = '{1'b1,1'b1,1'b0,32'h0,  32'h8,         32'h8,         1'b1,1'b0};
        vt[6]  = '{1'b1,1'b0,1'b0,32'h0,  32'hC,         32'hC,         1'b1,1'b0};
        vt[7]  = '{1'b1,1'b1,1'b1,32'd124,32'd124,       32'h0,         1'b0,1'b0};
        vt[8]  = '{1'b1,1'b0,1'b0,32'h0,  32'd128,       32'd128,       1'b1,1'b0};
        vt[9]  = '{1'b1,1'b0,1'b1,32'h42, 32'h40,        32'h0,         1'b0,1'b1};
        vt[10] = '{1'b1,1'b0,1'b0,32'h0,  32'h44,        32'h44,        1'b1,1'b1};
        vt[11] = '{1'b1,1'b0,1'b0,32'h0,  32'h48,        32'h48,        1'b1,1'b1};
        vt[12] = '{1'b1,1'b0,1'b1,32'h10, 32'h10,        32'h0,         1'b0,1'b1};
        vt[13] = '{1'b1,1'b1,1'b1,32'h20, 32'h20,        32'h0,         1'b0,1'b1};
        vt[14] = '{1'b1,1'b0,1'b0,32'h0,  32'h24,        32'h24,        1'b1,1'b1};
        vt[15] = '{1'b0,1'b0,1'b1,32'h80, 32'h0,         32'h0,         1'b0,1'b0};
        vt[16] = '{1'b0,1'b1,1'b0,32'h0,  32'h0,         32'h0,         1'b0,1'b0};
        vt[17] = '{1'b1,1'b0,1'b0,32'h0,  32'h4,         32'h4,         1'b1,1'b0};

        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 18; i++) begin
            step(vt[i].r, vt[i].f, vt[i].b, vt[i].a);
            chk($sformatf("vec%0d_addr", i),  imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_ipc", i),   if_id_pc,  vt[i].e_ipc);
            chk($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, vt[i].e_v});
            chk($sformatf("vec%0d_fault", i), {31'b0, fetch_fault}, {31'b0, vt[i].e_fault});
            if (i == 5) begin
`ifdef FETCH_PERF_CNT_EN
                chk("stall_cnt_3", perf_stall_cnt, 32'd3);
`else
                chk("stall_cnt_off", perf_stall_cnt, 32'd0);
`endif
            end
            if (i == 8) chk("target_word", if_id_instr, tag(32'd124));
            if (i == 7) chk("flush_nop", if_id_instr, NOP);
        end

        // Out-of-range fetch: from reset, run to pc=256 then one more fetch
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pc_at_256", imem_addr, 32'd256);
        chk("no_fault_252", {31'b0, fetch_fault}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("fault_256", {31'b0, fetch_fault}, 32'd1);

        // PC wrap from the top of the address space
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("pc_top", imem_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("pc_wrap", imem_addr, 32'h0);
        chk("ipc_wrap", if_id_pc, 32'h0);
        chk("instr_top", if_id_instr, tag(32'hFFFF_FFFC));
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset during stall clears the sticky fault
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("reset_fault_clr", {31'b0, fetch_fault}, 32'd0);

        if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
